fifo_t_wr_arbiter: RTL and testbench
====================================

// Module: fifo_t_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the write port of the fifo_t prefetch FIFO among N_REQ producers.
//  Grants are packet-locked: a granted producer keeps the port until its last beat or a burst cap.
//  Sits between producer blocks and the FIFO write side, in the FIFO write-clock domain.
// PARAMETERS
//  N_REQ      4   number of requesters, 2..8
//  DATA_WIDTH 12  beat width; equals the FIFO write data width
//  MAX_BURST  16  max beats per grant, 1..256
//  ID_W  $clog2(N_REQ), CNT_W $clog2(MAX_BURST+1)  derived localparams
// PORTS
//  clk           in   1              clock, single domain
//  rst_n         in   1              reset, synchronous, active-low
//  req_vld       in   N_REQ          per-requester beat valid
//  req_last      in   N_REQ          per-requester last beat of packet
//  req_data      in   N_REQ*DATA_W   requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
//  req_rdy       out  N_REQ          beat accepted when req_vld[i] & req_rdy[i]
//  fifo_wr_en    out  1              FIFO write enable
//  fifo_wr_data  out  DATA_WIDTH     FIFO write data
//  fifo_wr_vld   in   1              FIFO can accept a write this cycle
//  grant_id      out  ID_W           index of current/last grantee
//  busy          out  1              1 while in GRANT state
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0; all outputs 0.
//  Reset mid-burst aborts the packet; no fifo_wr_en in any cycle with rst_n=0.
//  FSM IDLE:
//   - any req_vld set -> select first set index at/after rr_ptr (modulo N_REQ).
//   - Register grant_id; go to GRANT.
//   - Latency req_vld -> first possible beat = 1 cycle.
//  FSM GRANT, g = grant_id:
//   - req_rdy[g] = fifo_wr_vld; all other req_rdy = 0.
//   - fifo_wr_en = req_vld[g] & fifo_wr_vld.
//   - fifo_wr_data = req_data slice g while fifo_wr_en, else 0. Combinational, zero added latency.
//   - Each accepted beat increments beat_cnt.
//   - Release when accepted beat has req_last[g]=1, or when beat_cnt reaches MAX_BURST.
//   - On release: rr_ptr = (g+1) mod N_REQ, beat_cnt=0, IDLE. One bubble cycle per grant.
//   - req_vld[g] dropping mid-packet does NOT release; grant is held and waits.
//  fifo_wr_vld=0: no write, no req_rdy, beat_cnt holds; data must be held by producer.
//  Release and new request in the same cycle: new request is seen in the following IDLE cycle.
//  rr_ptr wrap: N_REQ-1 -> 0. grant_id holds its value in IDLE.
//  Requests from non-granted producers are never dropped; they wait with req_rdy=0.
//  busy = (state==GRANT).
// CONFIGURATION
//  FIFO_T_ARB_STAT_EN defined:
//   - adds input stat_clr (1) and output stat_beats (N_REQ*16).
//   - Per-requester saturating count of accepted beats.
//   - stat_clr=1 zeroes all counters next cycle; counters are 0 after reset.
//   - Clear wins over a simultaneous increment.
//  Not defined: ports and counters absent; arbitration behaviour identical.
// TESTING
//  1. req0 sends 3 beats A,B,C (last on C), fifo_wr_vld=1 -> grant_id=0 one cycle later;
//     fifo_wr_en 3 cycles, data A,B,C; busy falls after C.
//  2. req0..3 all valid with 1-beat packets repeatedly -> grant order 0,1,2,3,0;
//     each grant is 1 beat + 1 bubble.
//  3. req1 sends 20 beats with no last, req2 pending, MAX_BURST=16 -> 16 beats from req1;
//     then req2 is granted; then req1 resumes at beat 17.
//  4. fifo_wr_vld=0 for 5 cycles mid-packet -> fifo_wr_en=0, req_rdy=0;
//     beat_cnt frozen; no beat lost or duplicated.
//  5. rst_n=0 during beat 2 of a burst -> next cycle all outputs 0, grant_id=0;
//     req3 then requests -> granted.
//  6. FIFO_T_ARB_STAT_EN defined, 5 beats from req2, then stat_clr pulse
//     -> stat_beats[2]=5, then 0; other counters stay 0.

Source files
------------

// File: rtl/fifo_t_wr_arbiter.sv
// Round-robin, packet-locked arbiter for the fifo_t prefetch FIFO write port.
// Optional per-requester beat counters: define FIFO_T_ARB_STAT_EN.
module fifo_t_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 12,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_vld,
    input  logic [N_REQ-1:0]              req_last,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_rdy,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_wr_vld,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          busy
`ifdef FIFO_T_ARB_STAT_EN
    ,
    input  logic                          stat_clr,
    output logic [N_REQ*16-1:0]           stat_beats
`endif
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   grant_d;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [CNT_W-1:0]  beat_cnt_d;

    logic [ID_W-1:0]       pick;
    logic                  pick_vld;
    logic                  in_grant;
    logic                  g_vld;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  accept;
    logic                  cap_hit;
    logic [ID_W-1:0]       next_ptr;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (req_vld[idx]) begin
                pick     = ID_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // Current grantee's signals; write path is gated while reset is held.
    always_comb begin
        in_grant = (state_q == GRANT) && rst_n;
        g_vld    = req_vld[grant_q];
        g_last   = req_last[grant_q];
        g_data   = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        accept   = in_grant && g_vld && fifo_wr_vld;
        cap_hit  = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
        if (grant_q == ID_W'(N_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_q + 1'b1;
        end
    end

    // Handshake outputs toward producers and the FIFO.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_rdy[i] = in_grant && fifo_wr_vld && (grant_q == ID_W'(i));
        end
        fifo_wr_en   = accept;
        fifo_wr_data = accept ? g_data : '0;
        grant_id     = grant_q;
        busy         = (state_q == GRANT);
    end

    // Next-state: lock onto a packet, release on last beat or burst cap.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    if (g_last || cap_hit) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        rr_ptr_d   = next_ptr;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_T_ARB_STAT_EN
    logic [15:0] stat_q [N_REQ];

    // Saturating accepted-beat counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (!rst_n || stat_clr) begin
                stat_q[i] <= '0;
            end else if (accept && (grant_q == ID_W'(i))
                         && (stat_q[i] != 16'hFFFF)) begin
                stat_q[i] <= stat_q[i] + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
        assign stat_beats[gi*16 +: 16] = stat_q[gi];
    end
`endif

endmodule

// File: tb/tb_fifo_t_wr_arbiter.sv
// Directed scoreboard bench for fifo_t_wr_arbiter.
// Producer queues feed the DUT; expected beats are checked per requester.
module tb_fifo_t_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_vld = '0;
    logic [N-1:0]      req_last = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_rdy;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic              fifo_wr_vld = 1'b1;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef FIFO_T_ARB_STAT_EN
    logic              stat_clr = 1'b0;
    logic [N*16-1:0]   stat_beats;
`endif

    fifo_t_wr_arbiter #(
        .N_REQ(N),
        .DATA_WIDTH(DW),
        .MAX_BURST(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_vld(req_vld),
        .req_last(req_last),
        .req_data(req_data),
        .req_rdy(req_rdy),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_wr_vld(fifo_wr_vld),
        .grant_id(grant_id),
        .busy(busy)
`ifdef FIFO_T_ARB_STAT_EN
        ,
        .stat_clr(stat_clr),
        .stat_beats(stat_beats)
`endif
    );

    always #5 clk = ~clk;

    logic [12:0] src_q [N][$];
    logic [DW-1:0] exp_q [N][$];
    int log_id [$];
    int log_cyc [$];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        logic [12:0] h;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                h = src_q[i][0];
                req_vld[i] = 1'b1;
                req_last[i] = h[12];
                req_data[i*DW +: DW] = h[DW-1:0];
            end else begin
                req_vld[i] = 1'b0;
                req_last[i] = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic push(int r, int n, bit last_end);
        logic [DW-1:0] d;
        logic          l;
        for (int k = 0; k < n; k++) begin
            d = DW'(r * 256 + k + 1);
            l = last_end && (k == n - 1);
            src_q[r].push_back({l, d});
            exp_q[r].push_back(d);
        end
    endtask

    task automatic tick();
        logic [N-1:0]  acc;
        logic [DW-1:0] e;
        int            g;
        @(negedge clk);
        if (!rst_n) chk("rst_no_wr", 32'(fifo_wr_en), 0);
        if (!fifo_wr_vld) begin
            chk("stall_wr_en", 32'(fifo_wr_en), 0);
            chk("stall_rdy", 32'(req_rdy), 0);
        end
        if (fifo_wr_en) begin
            g = int'(grant_id);
            log_id.push_back(g);
            log_cyc.push_back(cyc);
            chk("rdy_owner", 32'(req_rdy), 32'(1 << g));
            chk("wr_expected", 32'(exp_q[g].size() > 0), 1);
            if (exp_q[g].size() > 0) begin
                e = exp_q[g].pop_front();
                chk("wr_data", 32'(fifo_wr_data), 32'(e));
            end
        end
        acc = req_vld & req_rdy;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        drive();
        rst_n = 1'b0;
        ticks(2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_rdy", 32'(req_rdy), 0);
        chk("rst_data", 32'(fifo_wr_data), 0);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int s;
        int b;
        int tot;
        @(posedge clk);
        #1;
        do_reset();

        // 1: three-beat packet from req0
        b = log_id.size();
        s = cyc;
        push(0, 3, 1);
        drive();
        #1;
        chk("t1_idle_busy", 32'(busy), 0);
        tick();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_gid", 32'(grant_id), 0);
        ticks(3);
        chk("t1_busy_fall", 32'(busy), 0);
        chk("t1_nwr", 32'(log_id.size() - b), 3);
        for (int k = 0; k < 3; k++) begin
            chk("t1_cyc", 32'(log_cyc[b+k]), 32'(s + 1 + k));
            chk("t1_id", 32'(log_id[b+k]), 0);
        end

        // 2: all requesters with single-beat packets
        do_reset();
        b = log_id.size();
        s = cyc;
        for (int r = 0; r < N; r++) push(r, 1, 1);
        for (int r = 0; r < N; r++) push(r, 1, 1);
        drive();
        ticks(20);
        chk("t2_nwr", 32'(log_id.size() - b), 8);
        for (int k = 0; k < 8; k++) begin
            chk("t2_id", 32'(log_id[b+k]), 32'(k % N));
            chk("t2_cyc", 32'(log_cyc[b+k]), 32'(s + 1 + 2 * k));
        end

        // 3: burst cap on req1 with req2 pending
        do_reset();
        b = log_id.size();
        s = cyc;
        push(1, 20, 1);
        push(2, 2, 1);
        drive();
        ticks(30);
        chk("t3_nwr", 32'(log_id.size() - b), 22);
        for (int k = 0; k < 22; k++) begin
            chk("t3_id", 32'(log_id[b+k]),
                (k >= 16 && k < 18) ? 32'd2 : 32'd1);
        end
        chk("t3_req2_cyc", 32'(log_cyc[b+16]), 32'(s + 18));
        chk("t3_resume_cyc", 32'(log_cyc[b+18]), 32'(s + 21));

        // 4: FIFO back-pressure mid-packet
        do_reset();
        b = log_id.size();
        s = cyc;
        push(0, 18, 1);
        drive();
        ticks(4);
        fifo_wr_vld = 1'b0;
        #1;
        ticks(5);
        fifo_wr_vld = 1'b1;
        #1;
        ticks(20);
        chk("t4_nwr", 32'(log_id.size() - b), 18);
        chk("t4_resume", 32'(log_cyc[b+3]), 32'(s + 9));
        chk("t4_cap", 32'(log_cyc[b+15]), 32'(s + 21));
        chk("t4_regrant", 32'(log_cyc[b+16]), 32'(s + 23));

        // 5: reset during beat 2 of a req2 burst, then req3
        do_reset();
        b = log_id.size();
        push(2, 6, 1);
        drive();
        ticks(2);
        rst_n = 1'b0;
        #1;
        tick();
        src_q[2].delete();
        exp_q[2].delete();
        drive();
        rst_n = 1'b1;
        #1;
        chk("t5_nwr", 32'(log_id.size() - b), 1);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_gid", 32'(grant_id), 0);
        chk("t5_wr_en", 32'(fifo_wr_en), 0);
        chk("t5_rdy", 32'(req_rdy), 0);
        b = log_id.size();
        s = cyc;
        push(3, 1, 1);
        drive();
        ticks(3);
        chk("t5_nwr3", 32'(log_id.size() - b), 1);
        chk("t5_id3", 32'(log_id[b]), 3);
        chk("t5_cyc3", 32'(log_cyc[b]), 32'(s + 1));

`ifdef FIFO_T_ARB_STAT_EN
        // 6: beat statistics
        do_reset();
        for (int r = 0; r < N; r++)
            chk("t6_rst_stat", 32'(stat_beats[r*16 +: 16]), 0);
        push(2, 5, 1);
        drive();
        ticks(8);
        for (int r = 0; r < N; r++)
            chk("t6_stat", 32'(stat_beats[r*16 +: 16]), (r == 2) ? 32'd5 : 32'd0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        for (int r = 0; r < N; r++)
            chk("t6_clr", 32'(stat_beats[r*16 +: 16]), 0);
`endif

        tot = 0;
        for (int r = 0; r < N; r++) tot += exp_q[r].size();
        chk("exp_drained", 32'(tot), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
